// File: rtl/mux_nx1_pipe.sv
// N:1 datapath multiplexer with a registered output and a valid/ready handshake.
// Out-of-range select codes produce DEFAULT_VAL, flag out_sel_err and bump a
// saturating error counter.
//
// Build option: MUX_NX1_SKID_EN
//   undefined : single output register, in_ready = !out_valid || out_ready
//   defined   : extra skid entry, in_ready is a flop (no comb path from out_ready)
//
// Skid-mode states:
//   state    | meaning
//   ST_EMPTY | nothing held, out_valid=0
//   ST_ONE   | output register full, skid empty
//   ST_TWO   | output and skid full, in_ready=0
module mux_nx1_pipe #(
    parameter int               WIDTH       = 32,
    parameter int               N           = 3,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sel_err,
    output logic [7:0]           err_count
);

    logic [WIDTH-1:0] pick_data;
    logic             pick_err;
    logic             accept;
    logic             push;

    assign accept = in_valid && in_ready;
    assign push   = out_valid && out_ready;

    // Select the addressed word; any code without a matching input falls back to DEFAULT_VAL.
    always_comb begin
        pick_data = DEFAULT_VAL;
        pick_err  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                pick_data = in_data[k*WIDTH +: WIDTH];
                pick_err  = 1'b0;
            end
        end
    end

    // Count accepted out-of-range beats, sticking at 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (accept && pick_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

`ifdef MUX_NX1_SKID_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load_new;
    logic             load_from_skid;
    logic             load_skid;
    logic             in_ready_q;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = in_ready_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and storage load strobes.
    always_comb begin
        state_nxt      = state;
        load_new       = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_new  = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && push) begin
                    load_new = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = ST_TWO;
                end else if (push) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (push) begin
                    load_from_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // in_ready is registered from the upcoming state so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_nxt != ST_TWO);
        end
    end

    // Output and skid storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data    <= '0;
            out_sel_err <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
        end else begin
            if (load_new) begin
                out_data    <= pick_data;
                out_sel_err <= pick_err;
            end else if (load_from_skid) begin
                out_data    <= skid_data;
                out_sel_err <= skid_err;
            end
            if (load_skid) begin
                skid_data <= pick_data;
                skid_err  <= pick_err;
            end
        end
    end

`else

    assign in_ready = !out_valid || out_ready;

    // Single output register; a same-cycle accept and push simply overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sel_err <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_data    <= pick_data;
            out_sel_err <= pick_err;
        end else if (push) begin
            out_valid   <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: an N=3 instance driven by a vector table and hand-written
// stall/saturation/reset sequences, and an N=4 instance under random traffic.
// Both outputs are checked against queues of expected beats.
module tb_mux_nx1_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } beat_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // N=3 instance
    logic          reset = 1'b1;
    logic [95:0]   in_data_a = {32'h33, 32'h22, 32'h11};
    logic [1:0]    sel_a = 2'd0;
    logic          in_valid_a = 1'b0;
    logic          in_ready_a;
    logic [31:0]   out_data_a;
    logic          out_valid_a;
    logic          out_ready_a = 1'b1;
    logic          out_sel_err_a;
    logic [7:0]    err_count_a;

    // N=4 instance
    logic          reset_b4 = 1'b1;
    logic [127:0]  in_data_b = '0;
    logic [1:0]    sel_b = 2'd0;
    logic          in_valid_b = 1'b0;
    logic          in_ready_b;
    logic [31:0]   out_data_b;
    logic          out_valid_b;
    logic          out_ready_b = 1'b1;
    logic          out_sel_err_b;
    logic [7:0]    err_count_b;
    logic          b_done = 1'b0;

    beat_t qa[$];
    beat_t qb[$];
    beat_t mon_a;
    beat_t mon_b;

    mux_nx1_pipe #(.WIDTH(32), .N(3), .SEL_W(2), .DEFAULT_VAL(32'h0)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data_a),
        .sel         (sel_a),
        .in_valid    (in_valid_a),
        .in_ready    (in_ready_a),
        .out_data    (out_data_a),
        .out_valid   (out_valid_a),
        .out_ready   (out_ready_a),
        .out_sel_err (out_sel_err_a),
        .err_count   (err_count_a)
    );

    mux_nx1_pipe #(.WIDTH(32), .N(4), .SEL_W(2), .DEFAULT_VAL(32'h0)) dut_b (
        .clk         (clk),
        .reset       (reset_b4),
        .in_data     (in_data_b),
        .sel         (sel_b),
        .in_valid    (in_valid_b),
        .in_ready    (in_ready_b),
        .out_data    (out_data_b),
        .out_valid   (out_valid_b),
        .out_ready   (out_ready_b),
        .out_sel_err (out_sel_err_b),
        .err_count   (err_count_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus on the N=3 instance; the expected beat is queued if it is accepted.
    task automatic cycle_a(input logic v, input logic [1:0] s, input logic r,
                           input logic [31:0] ed, input logic ee, output logic acc);
        @(posedge clk);
        #1;
        in_valid_a  = v;
        sel_a       = s;
        out_ready_a = r;
        @(negedge clk);
        acc = v && in_ready_a;
        if (acc) qa.push_back(beat_t'{d: ed, e: ee});
    endtask

    task automatic idle_a(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle_a(1'b0, 2'd0, 1'b1, 32'h0, 1'b0, acc);
    endtask

    function automatic logic [31:0] word_a(input logic [1:0] s);
        case (s)
            2'd0:    return 32'h11;
            2'd1:    return 32'h22;
            2'd2:    return 32'h33;
            default: return 32'h0;
        endcase
    endfunction

    // Output side of the N=3 instance.
    always @(negedge clk) begin
        if (!reset && out_valid_a && out_ready_a) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_beat: got %h expected none", out_data_a);
            end else begin
                mon_a = qa.pop_front();
                check("a_data", out_data_a, mon_a.d);
                check("a_err", {31'd0, out_sel_err_a}, {31'd0, mon_a.e});
            end
        end
    end

    // Output and input side of the N=4 instance; pop first since the held beat predates any accept.
    always @(negedge clk) begin
        if (!reset_b4) begin
            if (out_valid_b && out_ready_b) begin
                if (qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected_beat: got %h expected none", out_data_b);
                end else begin
                    mon_b = qb.pop_front();
                    check("b_data", out_data_b, mon_b.d);
                    check("b_err", {31'd0, out_sel_err_b}, {31'd0, mon_b.e});
                end
            end
            if (in_valid_b && in_ready_b)
                qb.push_back(beat_t'{d: in_data_b[sel_b*32 +: 32], e: 1'b0});
        end
    end

    // Random traffic on the N=4 instance.
    initial begin
        repeat (3) @(posedge clk);
        #1 reset_b4 = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            in_data_b   = {$urandom, $urandom, $urandom, $urandom};
            sel_b       = 2'($urandom_range(0, 3));
            in_valid_b  = ($urandom_range(0, 1) != 0);
            out_ready_b = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
        repeat (6) @(posedge clk);
        b_done = 1'b1;
    end

    initial begin
        vec_t        tbl[7];
        logic        acc;
        int          acc_cnt;
        int          exp_acc;
        logic [31:0] held;

        tbl[0] = '{sel: 2'd0, exp_d: 32'h11, exp_e: 1'b0};
        tbl[1] = '{sel: 2'd1, exp_d: 32'h22, exp_e: 1'b0};
        tbl[2] = '{sel: 2'd2, exp_d: 32'h33, exp_e: 1'b0};
        tbl[3] = '{sel: 2'd1, exp_d: 32'h22, exp_e: 1'b0};
        tbl[4] = '{sel: 2'd2, exp_d: 32'h33, exp_e: 1'b0};
        tbl[5] = '{sel: 2'd3, exp_d: 32'h00, exp_e: 1'b1};
        tbl[6] = '{sel: 2'd0, exp_d: 32'h11, exp_e: 1'b0};

        // Reset values
        #12;
        check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_out_data", out_data_a, 32'd0);
        check("rst_sel_err", {31'd0, out_sel_err_a}, 32'd0);
        check("rst_err_count", {24'd0, err_count_a}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back beats, including accept+push in the same cycle and one bad select
        for (int i = 0; i < 7; i++) begin
            cycle_a(1'b1, tbl[i].sel, 1'b1, tbl[i].exp_d, tbl[i].exp_e, acc);
            check("tbl_accept", {31'd0, acc}, 32'd1);
            if (i > 0) check("tbl_out_valid", {31'd0, out_valid_a}, 32'd1);
        end
        idle_a(2);
        check("err_count_one", {24'd0, err_count_a}, 32'd1);
        check("drain_tbl", qa.size(), 32'd0);

        // Stall with in_valid held high
        acc_cnt = 0;
        held    = 32'h0;
        for (int i = 0; i < 5; i++) begin
            cycle_a(1'b1, 2'(i % 3), 1'b0, word_a(2'(i % 3)), 1'b0, acc);
            acc_cnt += int'(acc);
            if (i == 1) begin
                held = out_data_a;
                check("stall_first_word", out_data_a, 32'h11);
            end
            if (i == 4) begin
                check("stall_stable", out_data_a, held);
                check("stall_in_ready", {31'd0, in_ready_a}, 32'd0);
                check("stall_out_valid", {31'd0, out_valid_a}, 32'd1);
            end
        end
`ifdef MUX_NX1_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        check("stall_accepts", acc_cnt, exp_acc);
        idle_a(4);
        check("drain_stall", qa.size(), 32'd0);

        // Error counter saturation
        for (int i = 0; i < 253; i++) cycle_a(1'b1, 2'd3, 1'b1, 32'h0, 1'b1, acc);
        idle_a(1);
        check("err_count_254", {24'd0, err_count_a}, 32'd254);
        cycle_a(1'b1, 2'd3, 1'b1, 32'h0, 1'b1, acc);
        idle_a(1);
        check("err_count_255", {24'd0, err_count_a}, 32'd255);
        for (int i = 0; i < 46; i++) cycle_a(1'b1, 2'd3, 1'b1, 32'h0, 1'b1, acc);
        idle_a(2);
        check("err_count_sat", {24'd0, err_count_a}, 32'd255);
        check("drain_err", qa.size(), 32'd0);

        // Reset while storage is full, asserted between clock edges
        cycle_a(1'b1, 2'd1, 1'b0, 32'h22, 1'b0, acc);
        cycle_a(1'b1, 2'd2, 1'b0, 32'h33, 1'b0, acc);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("mid_rst_out_data", out_data_a, 32'd0);
        check("mid_rst_sel_err", {31'd0, out_sel_err_a}, 32'd0);
        check("mid_rst_err_count", {24'd0, err_count_a}, 32'd0);
        qa.delete();
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("post_rst_err_count", {24'd0, err_count_a}, 32'd0);
        check("post_rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        cycle_a(1'b1, 2'd2, 1'b1, 32'h33, 1'b0, acc);
        idle_a(2);
        check("post_rst_drain", qa.size(), 32'd0);

        // Wait for the random run on the N=4 instance
        for (int i = 0; i < 20000 && !b_done; i++) @(posedge clk);
        if (!b_done) begin
            total++;
            bad++;
            $display("FAIL rand_timeout: got not done expected done");
        end
        @(negedge clk);
        check("rand_drain", qb.size(), 32'd0);
        check("rand_err_count", {24'd0, err_count_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
